// File: rtl/register_file_pkg.sv
// Shared constants for the decode-stage register file.
package register_file_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  // True when a write-back request actually targets storage ($zero has none).
  function automatic logic reg_write_hits(input logic                      we,
                                          input logic [REG_ADDR_WIDTH-1:0] addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: $zero, optional write-through bypass, then stored value.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM        = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] regs_i [1:NUM-1],
  input  logic                  byp_en_i,
  input  logic [ADDR_WIDTH-1:0] byp_addr_i,
  input  logic [DATA_WIDTH-1:0] byp_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    if (addr_i == '0) begin
      data_o = '0;
    end else if (byp_en_i && (byp_addr_i == addr_i)) begin
      data_o = byp_data_i;
    end else begin
      data_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS GPR file: 32x32, two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_1_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_2_i,
  output logic [DATA_WIDTH-1:0] read_data_1_o,
  output logic [DATA_WIDTH-1:0] read_data_2_o,
  input  logic                  should_write_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i
);

  localparam int NUM = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [1:NUM-1];
  logic                  wr_hit;
  logic                  byp_en;

  assign wr_hit = should_write_i && (write_addr_i != '0);

`ifdef REGFILE_BYPASS_EN
  assign byp_en = wr_hit && !reset_i;
`else
  assign byp_en = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 1; i < NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_q[write_addr_i] <= write_data_i;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM       (NUM)
  ) u_port_1 (
    .addr_i    (read_addr_1_i),
    .regs_i    (regs_q),
    .byp_en_i  (byp_en),
    .byp_addr_i(write_addr_i),
    .byp_data_i(write_data_i),
    .data_o    (read_data_1_o)
  );

  register_file_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM       (NUM)
  ) u_port_2 (
    .addr_i    (read_addr_2_i),
    .regs_i    (regs_q),
    .byp_en_i  (byp_en),
    .byp_addr_i(write_addr_i),
    .byp_data_i(write_data_i),
    .data_o    (read_data_2_o)
  );

endmodule
